// File: rtl/ldm_stm_seq.sv
// rtl/ldm_stm_seq.sv - LDM/STM-style register-list block-transfer sequencer
module ldm_stm_seq #(
   parameter int AW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          load,
   input  logic          up,
   input  logic [15:0]   reglist,
   input  logic [AW-1:0] base,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] wb_addr,
   output logic [3:0]    raddr,
   input  logic [31:0]   rdata,
   output logic          w_en,
   output logic [3:0]    waddr,
   output logic [31:0]   wdata,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic          mem_ack,
   input  logic [31:0]   mem_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic            load_q;
   logic [15:0]     remain;
   logic [15:0]     remain_nxt;
   logic [AW-1:0]   addr_q;
   logic [4:0]      cnt;
   logic [AW-1:0]   span;
   logic [3:0]      cur_reg;

   // Number of registers named by the incoming list (0..16).
   always_comb begin
      cnt = '0;
      for (int i = 0; i < 16; i++) begin
         cnt = cnt + {4'b0, reglist[i]};
      end
   end

   // Byte span of the whole block; lowest register always sits at the lowest address.
   assign span = {{(AW-5){1'b0}}, cnt} << 2;

   // Current register is the lowest set bit still pending.
   always_comb begin
      cur_reg = '0;
      for (int i = 15; i >= 0; i--) begin
         if (remain[i]) begin
            cur_reg = 4'(i);
         end
      end
   end

   assign remain_nxt = remain & (remain - 16'd1);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; START is only honoured from IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = (cnt != 5'd0) ? XFER : FIN;
            end
         end
         XFER: begin
            if (mem_ack && (remain_nxt == 16'd0)) begin
               state_nxt = FIN;
            end
         end
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode; request fields come straight from held state so they stay stable across waits.
   always_comb begin
      busy      = 1'b0;
      done      = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      raddr     = '0;
      w_en      = 1'b0;
      waddr     = '0;
      wdata     = '0;
      case (state)
         XFER: begin
            busy      = 1'b1;
            mem_req   = 1'b1;
            mem_we    = ~load_q;
            mem_addr  = addr_q;
            raddr     = cur_reg;
            mem_wdata = rdata;
            if (load_q && mem_ack) begin
               w_en  = 1'b1;
               waddr = cur_reg;
               wdata = mem_rdata;
            end
         end
         FIN: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   // Transfer context: latched at START, list/address stepped on each acknowledged beat.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         load_q  <= 1'b0;
         remain  <= '0;
         addr_q  <= '0;
         wb_addr <= '0;
      end else begin
         if (state == IDLE && start) begin
            load_q  <= load;
            remain  <= reglist;
            addr_q  <= up ? base : base - span;
            wb_addr <= up ? base + span : base - span;
         end else if (state == XFER && mem_ack) begin
            remain <= remain_nxt;
            addr_q <= addr_q + AW'(32'd4);
         end
      end
   end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// tb/tb_ldm_stm_seq.sv - scoreboard bench for ldm_stm_seq
module tb_ldm_stm_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        load = 1'b0;
   logic        up = 1'b0;
   logic [15:0] reglist = '0;
   logic [31:0] base = '0;
   logic        busy, done, w_en, mem_req, mem_we;
   logic [31:0] wb_addr, mem_addr, mem_wdata, wdata, rdata, mem_rdata;
   logic [3:0]  raddr, waddr;
   logic        mem_ack = 1'b0;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  r;
      logic [31:0] data;
   } acc_t;

   acc_t        exp_acc[$];
   logic [31:0] exp_wb[$];
   acc_t        e;
   logic [31:0] rf[16];
   logic [31:0] model_rf[16];
   logic        preload = 1'b1;
   int          ack_mode = 0;
   int          wcnt = 0;
   int          checks = 0;
   int          errors = 0;
   logic        pend = 1'b0;
   logic [31:0] p_addr;
   logic        p_we;

   ldm_stm_seq #(.AW(32)) dut (
      .clk(clk), .rst(rst), .start(start), .load(load), .up(up),
      .reglist(reglist), .base(base), .busy(busy), .done(done),
      .wb_addr(wb_addr), .raddr(raddr), .rdata(rdata), .w_en(w_en),
      .waddr(waddr), .wdata(wdata), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   assign rdata     = rf[raddr];
   assign mem_rdata = mem_val(mem_addr);

   // Register file that the sequencer writes into.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 16; i++) rf[i] <= model_rf[i];
      end else if (w_en) begin
         rf[waddr] <= wdata;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic bad(input string nm);
      checks++;
      errors++;
      $display("FAIL %s actual=event required=none", nm);
   endtask

   // Memory responder: always-ack, random ack, or exactly two wait cycles per request.
   always @(posedge clk) begin
      #2;
      if (!rst) begin
         mem_ack = 1'b0;
         wcnt    = 0;
      end else begin
         case (ack_mode)
            0: mem_ack = 1'b1;
            1: mem_ack = ($urandom_range(0, 3) != 0);
            default: begin
               if (mem_req) begin
                  if (wcnt == 2) begin
                     mem_ack = 1'b1;
                     wcnt    = 0;
                  end else begin
                     mem_ack = 1'b0;
                     wcnt++;
                  end
               end else begin
                  mem_ack = 1'b0;
               end
            end
         endcase
      end
   end

   // Monitor: compares every completed beat and completion pulse with the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         pend = 1'b0;
      end else begin
         if (pend) begin
            chk("req_held", mem_req, 1);
            chk("addr_held", mem_addr, p_addr);
            chk("we_held", mem_we, p_we);
         end
         if (mem_req && mem_ack) begin
            if (exp_acc.size() == 0) begin
               bad("unexpected_access");
            end else begin
               e = exp_acc.pop_front();
               chk("mem_addr", mem_addr, e.addr);
               chk("mem_we", mem_we, e.we);
               if (e.we) begin
                  chk("mem_wdata", mem_wdata, e.data);
                  chk("w_en_store", w_en, 0);
               end else begin
                  chk("w_en_load", w_en, 1);
                  chk("waddr", waddr, e.r);
                  chk("wdata", wdata, e.data);
               end
            end
         end else begin
            chk("w_en_no_ack", w_en, 0);
         end
         pend   = mem_req && !mem_ack;
         p_addr = mem_addr;
         p_we   = mem_we;
         if (done) begin
            if (exp_wb.size() == 0) begin
               bad("unexpected_done");
            end else begin
               chk("wb_addr", wb_addr, exp_wb.pop_front());
            end
            chk("busy_in_fin", busy, 1);
            chk("req_in_fin", mem_req, 0);
         end
      end
   end

   // Issue one transfer from an IDLE cycle (entered at posedge+1) and follow it to IDLE.
   task automatic do_xfer(input logic ld, input logic u, input logic [15:0] list,
                          input logic [31:0] b, input int mode, input bit poke);
      int          n;
      int          c;
      logic [31:0] a;
      logic [31:0] wb;
      logic [31:0] tmp;
      ack_mode = mode;
      n = 0;
      for (int r = 0; r < 16; r++) if (list[r]) n++;
      a  = u ? b : b - 32'(4 * n);
      wb = u ? b + 32'(4 * n) : b - 32'(4 * n);
      for (int r = 0; r < 16; r++) begin
         if (list[r]) begin
            exp_acc.push_back('{addr: a, we: !ld, r: 4'(r), data: ld ? mem_val(a) : model_rf[r]});
            if (ld) model_rf[r] = mem_val(a);
            a = a + 32'd4;
         end
      end
      exp_wb.push_back(wb);
      chk("idle_before_start", busy, 0);
      start = 1'b1; load = ld; up = u; reglist = list; base = b;
      @(posedge clk); #1;
      start = 1'b0;
      tmp = $urandom; reglist = tmp[15:0]; base = $urandom; load = ~ld; up = ~u;
      c = 1;
      while (!done && c < 400) begin
         if (poke && c == 2) begin
            start = 1'b1; reglist = 16'hFFFF; base = $urandom;
         end
         @(posedge clk); #1;
         start = 1'b0;
         c++;
      end
      if (!done) begin
         bad("done_timeout");
      end else begin
         if (mode == 0) chk("done_cycle", c, n + 1);
         if (mode == 2) chk("done_cycle_wait", c, 3 * n + 1);
         if (poke) start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         chk("busy_after_fin", busy, 0);
         chk("wb_held", wb_addr, wb);
      end
   endtask

   initial begin
      logic [31:0] tmp;
      int          sel;
      logic [15:0] list;
      for (int i = 0; i < 16; i++) model_rf[i] = $urandom;
      model_rf[0] = 32'h11; model_rf[1] = 32'h22; model_rf[4] = 32'h44;
      #3;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_req", mem_req, 0);
      chk("rst_w_en", w_en, 0);
      chk("rst_wb", wb_addr, 0);
      chk("rst_mem_addr", mem_addr, 0);
      @(posedge clk); @(posedge clk); #2;
      preload = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;

      do_xfer(1'b0, 1'b1, 16'h0013, 32'h100, 0, 1'b0);
      do_xfer(1'b1, 1'b0, 16'h8001, 32'h200, 2, 1'b0);
      do_xfer(1'b1, 1'b1, 16'h0000, 32'h40, 0, 1'b0);
      do_xfer(1'b0, 1'b1, 16'hFFFF, 32'hFFFFFFF8, 0, 1'b0);
      do_xfer(1'b0, 1'b0, 16'h00F0, 32'h500, 0, 1'b1);

      // Reset during a load, one cycle before the acknowledge arrives.
      ack_mode = 2;
      start = 1'b1; load = 1'b1; up = 1'b1; reglist = 16'h0004; base = 32'h300;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #3;
      rst = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_req", mem_req, 0);
      chk("mid_rst_we", mem_we, 0);
      chk("mid_rst_w_en", w_en, 0);
      chk("mid_rst_addr", mem_addr, 0);
      chk("mid_rst_raddr", raddr, 0);
      chk("mid_rst_waddr", waddr, 0);
      chk("mid_rst_wdata", wdata, 0);
      chk("mid_rst_mem_wdata", mem_wdata, 0);
      chk("mid_rst_wb", wb_addr, 0);
      @(posedge clk); @(posedge clk); #4;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("idle_after_rst", busy, 0);
      chk("no_write_in_rst", rf[2], model_rf[2]);
      do_xfer(1'b1, 1'b1, 16'h0006, 32'h600, 1, 1'b0);

      for (int k = 0; k < 40; k++) begin
         sel = $urandom_range(0, 7);
         tmp = $urandom;
         list = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'hFFFF : tmp[15:0];
         tmp = $urandom;
         do_xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), list,
                 tmp & 32'hFFFFFFFC, $urandom_range(0, 2), 1'b0);
      end

      repeat (4) @(posedge clk);
      #1;
      chk("acc_queue_empty", exp_acc.size(), 0);
      chk("wb_queue_empty", exp_wb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
